// File: rtl/rom_lane_streamer_pkg.sv
`default_nettype none
// ============================================================================
// rom_stream_pkg : shared types and helpers for the ROM lane streamer
// Revision 1.0
// ============================================================================
package rom_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_LANES = 4;

  typedef logic [DEF_LANES-1:0] lane_mask_t;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage : rom_stream_pkg
`default_nettype wire

// File: rtl/rom_lane_streamer_if.sv
`default_nettype none
// ============================================================================
// rom_lane_streamer_if : control, ROM-head and output-beat bundle
// Revision 1.0
// ============================================================================
interface rom_lane_streamer_if #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 16,
  parameter int LANES     = 4
);

  logic                                start;
  logic [ADDR_BITS-1:0]                start_addr;
  logic [ADDR_BITS:0]                  len;
  logic                                busy;
  logic                                done;
  logic [LANES-1:0][ADDR_BITS-1:0]     rom_addrs;
  logic [LANES-1:0][DATA_BITS-1:0]     rom_data;
  logic                                out_valid;
  logic                                out_ready;
  logic [LANES-1:0][DATA_BITS-1:0]     out_data;
  logic [LANES-1:0]                    out_mask;
  logic                                out_last;

  // The streamer itself is the slave; the environment (control + ROM + sink) is the master.
  modport slave (
    input  start, start_addr, len, rom_data, out_ready,
    output busy, done, rom_addrs, out_valid, out_data, out_mask, out_last
  );

  modport master (
    output start, start_addr, len, rom_data, out_ready,
    input  busy, done, rom_addrs, out_valid, out_data, out_mask, out_last
  );

endinterface : rom_lane_streamer_if
`default_nettype wire

// File: rtl/rom_lane_streamer_addr_gen.sv
`default_nettype none
// ============================================================================
// rom_lane_addr_gen : per-lane ROM head addresses and in-range flags
// Revision 1.0
// ============================================================================
module rom_lane_addr_gen #(
  parameter int ADDR_BITS = 16,
  parameter int MAX_ADDR  = 2048,
  parameter int LANES     = 4
) (
  input  logic [ADDR_BITS:0]              cur_addr_i,
  output logic [LANES-1:0][ADDR_BITS-1:0] rom_addrs_o,
  output logic [LANES-1:0]                in_range_o
);

  localparam int            c_aw       = ADDR_BITS + 1;
  localparam logic [c_aw-1:0] c_max_addr = c_aw'(MAX_ADDR);

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [c_aw-1:0] w_sum;
      assign w_sum = cur_addr_i + c_aw'(i);
      // Heads see the truncated address; range is judged on the wide sum.
      assign rom_addrs_o[i] = w_sum[ADDR_BITS-1:0];
      assign in_range_o[i]  = (w_sum < c_max_addr);
    end
  endgenerate

endmodule : rom_lane_addr_gen
`default_nettype wire

// File: rtl/rom_lane_streamer.sv
`default_nettype none
// ============================================================================
// rom_lane_streamer : streams a ROM window as LANES-wide valid/ready beats
// Revision 1.0
// ============================================================================
module rom_lane_streamer
  import rom_stream_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 16,
  parameter int MAX_ADDR  = 2048,
  parameter int LANES     = 4
) (
  input  logic                clk,
  input  logic                rst,
  rom_lane_streamer_if.slave  bus
);

  localparam int         c_aw      = ADDR_BITS + 1;
  localparam logic [1:0] c_st_idle = IDLE;
  localparam logic [1:0] c_st_run  = RUN;
  localparam logic [1:0] c_st_done = DONE;

  logic [1:0]                      state_q, state_d;
  logic [c_aw-1:0]                 cur_addr_q, cur_addr_d;
  logic [c_aw-1:0]                 remaining_q, remaining_d;
  logic                            out_valid_q, out_valid_d;
  logic                            out_last_q, out_last_d;
  logic [LANES-1:0][DATA_BITS-1:0] out_data_q, out_data_d;
  logic [LANES-1:0]                out_mask_q, out_mask_d;

  logic [LANES-1:0][ADDR_BITS-1:0] w_rom_addrs;
  logic [LANES-1:0]                w_in_range;
  logic                            w_fetch;
  logic                            w_hs;

  rom_lane_addr_gen #(
    .ADDR_BITS (ADDR_BITS),
    .MAX_ADDR  (MAX_ADDR),
    .LANES     (LANES)
  ) u_addr_gen (
    .cur_addr_i  (cur_addr_q),
    .rom_addrs_o (w_rom_addrs),
    .in_range_o  (w_in_range)
  );

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;

    w_hs    = out_valid_q && bus.out_ready;
    w_fetch = (state_q == c_st_run) && (remaining_q != '0) && (!out_valid_q || bus.out_ready);

    case (state_q)
      c_st_idle: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            state_d     = c_st_run;
            cur_addr_d  = {1'b0, bus.start_addr};
            remaining_d = bus.len;
          end else begin
            state_d = c_st_done;
          end
        end
      end
      c_st_run: begin
        if (w_hs && out_last_q) begin
          state_d = c_st_done;
        end
      end
      c_st_done: state_d = c_st_idle;
      default:   state_d = c_st_idle;
    endcase

    // Output stage refills when empty or draining; otherwise a handshake empties it.
    if (w_fetch) begin
      for (int i = 0; i < LANES; i++) begin
        out_data_d[i] = w_in_range[i] ? bus.rom_data[i] : '0;
        out_mask_d[i] = (c_aw'(i) < remaining_q);
      end
      out_valid_d = 1'b1;
      out_last_d  = (remaining_q <= c_aw'(LANES));
      cur_addr_d  = cur_addr_q + c_aw'(LANES);
      remaining_d = remaining_q - c_aw'(min_u(32'(remaining_q), LANES));
    end else if (w_hs) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= c_st_idle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
    end
  end

  assign bus.busy      = (state_q == c_st_run);
  assign bus.done      = (state_q == c_st_done);
  assign bus.rom_addrs = w_rom_addrs;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_mask  = out_mask_q;

endmodule : rom_lane_streamer
`default_nettype wire

// File: tb/tb_rom_lane_streamer.sv
`default_nettype none
// ============================================================================
// tb_rom_lane_streamer : scoreboard bench for rom_lane_streamer (LANES=4)
// Revision 1.0
// ============================================================================
module tb_rom_lane_streamer;
  import rom_stream_pkg::*;

  localparam int DATA_BITS = 8;
  localparam int ADDR_BITS = 16;
  localparam int MAX_ADDR  = 2048;
  localparam int LANES     = 4;

  typedef struct {
    logic [LANES*DATA_BITS-1:0] data;
    lane_mask_t                 mask;
    logic                       last;
  } beat_t;

  logic  clk;
  logic  rst;
  int    n_cmp;
  int    n_err;
  int    beat_cnt;
  logic  done_exp;
  beat_t sb_q[$];

  rom_lane_streamer_if #(
    .DATA_BITS (DATA_BITS),
    .ADDR_BITS (ADDR_BITS),
    .LANES     (LANES)
  ) bus ();

  rom_lane_streamer #(
    .DATA_BITS (DATA_BITS),
    .ADDR_BITS (ADDR_BITS),
    .MAX_ADDR  (MAX_ADDR),
    .LANES     (LANES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: word = address & 0xFF; out-of-range heads return garbage the DUT must zero.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      bus.rom_data[i] = (int'(bus.rom_addrs[i]) < MAX_ADDR) ? bus.rom_addrs[i][7:0] : 8'hA5;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_window(input int sa, input int len);
    for (int b = 0; b * LANES < len; b++) begin
      beat_t e;
      int    cur;
      int    rem;
      cur = sa + b * LANES;
      rem = len - b * LANES;
      for (int i = 0; i < LANES; i++) begin
        e.data[i*DATA_BITS +: DATA_BITS] = ((cur + i) < MAX_ADDR) ? 8'((cur + i) & 255) : 8'h00;
        e.mask[i] = (i < rem);
      end
      e.last = (rem <= LANES);
      sb_q.push_back(e);
    end
  endtask

  // Monitor: compares the pending beat every valid cycle (so stalls must hold data),
  // pops on handshake, and tracks when a done pulse is due.
  always @(negedge clk) begin
    if (rst) begin
      done_exp = 1'b0;
    end else begin
      if (done_exp || bus.done) check_val("done_pulse", 64'(bus.done), 64'(done_exp));
      done_exp = (bus.out_valid && bus.out_ready && bus.out_last) ||
                 (bus.start && (bus.len == '0));
      if (bus.out_valid) begin
        if (sb_q.size() == 0) begin
          check_val("spurious_valid", 64'(1), 64'(0));
        end else begin
          logic [LANES*DATA_BITS-1:0] m;
          for (int i = 0; i < LANES; i++) m[i*DATA_BITS +: DATA_BITS] = {DATA_BITS{sb_q[0].mask[i]}};
          check_val("beat_data", 64'(bus.out_data & m), 64'(sb_q[0].data & m));
          check_val("beat_mask", 64'(bus.out_mask), 64'(sb_q[0].mask));
          check_val("beat_last", 64'(bus.out_last), 64'(sb_q[0].last));
          if (bus.out_ready) begin
            void'(sb_q.pop_front());
            beat_cnt++;
          end
        end
      end
    end
  end

  task automatic run_window(input int sa, input int len, input bit toggle, input bit chk_lat);
    bit       seen_done;
    int       cyc;
    bit [3:0] pat;
    pat      = 4'b1001;
    beat_cnt = 0;
    push_window(sa, len);
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.start_addr = ADDR_BITS'(sa);
    bus.len        = (ADDR_BITS+1)'(len);
    bus.out_ready  = toggle ? pat[0] : 1'b1;
    seen_done = 1'b0;
    cyc       = 0;
    while (!seen_done && cyc < 200) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      cyc++;
      if (chk_lat && cyc == 1) check_val("lat_c1_valid", 64'(bus.out_valid), 64'(0));
      if (chk_lat && cyc == 2) check_val("lat_c2_valid", 64'(bus.out_valid), 64'(1));
      if (len == 0 && cyc == 1) check_val("len0_busy", 64'(bus.busy), 64'(0));
      bus.out_ready = toggle ? pat[cyc % 4] : 1'b1;
      if (bus.done) seen_done = 1'b1;
    end
    if (!seen_done) check_val("done_timeout", 64'(0), 64'(1));
    check_val("sb_empty", 64'(sb_q.size()), 64'(0));
    check_val("beat_count", 64'(beat_cnt), 64'((len + LANES - 1) / LANES));
    bus.out_ready = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_busy"},  64'(bus.busy),      64'(0));
    check_val({tag, "_done"},  64'(bus.done),      64'(0));
    check_val({tag, "_valid"}, 64'(bus.out_valid), 64'(0));
    check_val({tag, "_last"},  64'(bus.out_last),  64'(0));
    check_val({tag, "_data"},  64'(bus.out_data),  64'(0));
    check_val({tag, "_mask"},  64'(bus.out_mask),  64'(0));
    check_val({tag, "_addr0"}, 64'(bus.rom_addrs[0]), 64'(0));
    check_val({tag, "_addr3"}, 64'(bus.rom_addrs[3]), 64'(3));
  endtask

  initial begin
    int guard;
    n_cmp          = 0;
    n_err          = 0;
    beat_cnt       = 0;
    done_exp       = 1'b0;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.len        = '0;
    bus.out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    run_window(0, 8, 1'b0, 1'b1);
    run_window(10, 6, 1'b0, 1'b0);
    run_window(2046, 4, 1'b0, 1'b0);
    run_window(5, 0, 1'b0, 1'b0);
    run_window(20, 12, 1'b1, 1'b0);
    run_window(2045, 7, 1'b1, 1'b0);

    // Abandon a window after its first beat.
    beat_cnt = 0;
    push_window(100, 12);
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.start_addr = 16'd100;
    bus.len        = 17'd12;
    guard = 0;
    while (beat_cnt < 1 && guard < 20) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      guard++;
    end
    if (beat_cnt < 1) check_val("midrst_timeout", 64'(0), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("midrst");
    rst = 1'b0;
    sb_q.delete();
    @(posedge clk); #1;
    check_val("midrst_no_done", 64'(bus.done), 64'(0));
    run_window(200, 5, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_rom_lane_streamer
`default_nettype wire
